// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the integer datapath.
//   XLEN        datapath width
//   REG_ADDR_W  architectural register address width
//   WB_SEL_*    writeback source encodings (2'b11 is reserved, decoded as ALU)
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_ALU = 2'b00;
  localparam wb_sel_t WB_SEL_MEM = 2'b01;
  localparam wb_sel_t WB_SEL_PC4 = 2'b10;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x XLEN architectural register file.
// The file has two combinational read ports and one synchronous write port.
// Entry 0 is hardwired to zero. A write in flight is bypassed to both read
// ports in the same cycle, so a reader never sees the stale array value.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears every entry)
//   wen/waddr/wdata write port; the write lands in the array at the clk edge
//   raddr1/rdata1   read port 1 (combinational)
//   raddr2/rdata2   read port 2 (combinational)
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // x0 is filtered here as well, so the array never holds a nonzero entry 0
  // even if a caller asserts wen with waddr == 0.
  always_comb begin
    regs_d = regs_q;
    if (wen && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // The bypass is checked after the x0 test, so a write aimed at x0 can
  // never leak onto a read of x0.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wen && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wen && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback end of the integer datapath.
// The module holds the MEM/WB pipeline register and selects the writeback value
// (ALU result, load data or PC+4). It drives the register file write and serves
// the two operand read ports with a same-cycle bypass.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall, flush           hold MEM/WB / load a bubble (flush wins)
//   mem_*                  MEM-stage instruction fields captured into MEM/WB
//   rs1_addr/rs2_addr      read addresses
//   rs1_data/rs2_data      combinational read data (bypassed)
//   wb_wen/wb_rd/wb_data   architectural write this cycle, also for forwarding
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_wen,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [XLEN-1:0]       mem_alu_out,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       mem_pc,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  wb_wen,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data
);

  // MEM/WB pipeline register
  logic                  valid_q,   valid_d;
  logic                  reg_wen_q, reg_wen_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  wb_sel_t               wb_sel_q,  wb_sel_d;
  logic [XLEN-1:0]       alu_out_q, alu_out_d;
  logic [XLEN-1:0]       rdata_q,   rdata_d;
  logic [XLEN-1:0]       pc_q,      pc_d;

  // A flush only clears valid; the payload fields are left as they are,
  // because nothing downstream looks at them while valid is low.
  always_comb begin
    valid_d   = valid_q;
    reg_wen_d = reg_wen_q;
    rd_d      = rd_q;
    wb_sel_d  = wb_sel_q;
    alu_out_d = alu_out_q;
    rdata_d   = rdata_q;
    pc_d      = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d   = mem_valid;
      reg_wen_d = mem_reg_wen;
      rd_d      = mem_rd;
      wb_sel_d  = mem_wb_sel;
      alu_out_d = mem_alu_out;
      rdata_d   = mem_rdata;
      pc_d      = mem_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= WB_SEL_ALU;
      alu_out_q <= '0;
      rdata_q   <= '0;
      pc_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      reg_wen_q <= reg_wen_d;
      rd_q      <= rd_d;
      wb_sel_q  <= wb_sel_d;
      alu_out_q <= alu_out_d;
      rdata_q   <= rdata_d;
      pc_q      <= pc_d;
    end
  end

  // Writeback select; PC+4 wraps modulo 2^XLEN, and the reserved
  // encoding falls back to the ALU result.
  always_comb begin
    unique case (wb_sel_q)
      WB_SEL_ALU: wb_data = alu_out_q;
      WB_SEL_MEM: wb_data = rdata_q;
      WB_SEL_PC4: wb_data = pc_q + XLEN'(4);
      default:    wb_data = alu_out_q;
    endcase
  end

  assign wb_wen = valid_q & reg_wen_q & (rd_q != '0);
  assign wb_rd  = rd_q;

  // Register array write and read
  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wen    (wb_wen),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .rdata1 (rs1_data),
    .raddr2 (rs2_addr),
    .rdata2 (rs2_data)
  );

endmodule
